// File: rtl/regfile_mp.sv
// Multi-port register file: 3 async reads, 2 sync writes (port 2 wins), sweep-based clear.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 32,
    parameter int unsigned AddrW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Clear,
    input  logic             RegWrite1,
    input  logic [AddrW-1:0] W1,
    input  logic [Width-1:0] WD1,
    input  logic             RegWrite2,
    input  logic [AddrW-1:0] W2,
    input  logic [Width-1:0] WD2,
    input  logic [AddrW-1:0] R1,
    input  logic [AddrW-1:0] R2,
    input  logic [AddrW-1:0] R3,
    output logic [Width-1:0] RD1,
    output logic [Width-1:0] RD2,
    output logic [Width-1:0] RD3,
    output logic             Busy
);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    localparam logic [AddrW-1:0] LastIdx = AddrW'(Depth - 1);

    state_e             state_q;
    logic [AddrW-1:0]   cnt_q;
    logic               busy_q;
    logic [Width-1:0]   mem_q [Depth];

    logic               wr1_en;
    logic               wr2_en;
    logic [AddrW-1:0]   raddr [3];
    logic [Width-1:0]   rdata [3];

    // Entry 0 is hard-wired to read zero, so it is never a legal write/read target.
    function automatic logic in_range(input logic [AddrW-1:0] a);
        return (a != '0) && (32'(a) < Depth);
    endfunction

    assign wr1_en = RegWrite1 && in_range(W1) && !busy_q;
    assign wr2_en = RegWrite2 && in_range(W2) && !busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StSweep;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StSweep: begin
                    if (cnt_q == LastIdx) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (Clear) begin
                        state_q <= StSweep;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StSweep;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Array is left untouched on the reset edge; the sweep that follows rewrites it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (busy_q) begin
                mem_q[cnt_q] <= Width'(cnt_q);
            end else begin
                if (wr1_en) mem_q[W1] <= WD1;
                if (wr2_en) mem_q[W2] <= WD2;
            end
        end
    end

    assign raddr[0] = R1;
    assign raddr[1] = R2;
    assign raddr[2] = R3;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rdata[k] = '0;
            if (!busy_q && in_range(raddr[k])) begin
                rdata[k] = mem_q[raddr[k]];
`ifdef REGFILE_BYPASS_EN
                if (wr1_en && (W1 == raddr[k])) rdata[k] = WD1;
                if (wr2_en && (W2 == raddr[k])) rdata[k] = WD2;
`endif
            end
        end
    end

    assign RD1  = rdata[0];
    assign RD2  = rdata[1];
    assign RD3  = rdata[2];
    assign Busy = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default 32-entry instance plus a 24-entry one
// sharing the same stimulus to exercise out-of-range addressing.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        Clear;
    logic        RegWrite1;
    logic [4:0]  W1;
    logic [31:0] WD1;
    logic        RegWrite2;
    logic [4:0]  W2;
    logic [31:0] WD2;
    logic [4:0]  R1;
    logic [4:0]  R2;
    logic [4:0]  R3;
    logic [31:0] RD1, RD2, RD3;
    logic        Busy;
    logic [31:0] s_RD1, s_RD2, s_RD3;
    logic        s_Busy;

    int checks   = 0;
    int failures = 0;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .Clear(Clear),
        .RegWrite1(RegWrite1), .W1(W1), .WD1(WD1),
        .RegWrite2(RegWrite2), .W2(W2), .WD2(WD2),
        .R1(R1), .R2(R2), .R3(R3),
        .RD1(RD1), .RD2(RD2), .RD3(RD3), .Busy(Busy)
    );

    regfile_mp #(.Width(32), .Depth(24), .AddrW(5)) dut24 (
        .clk(clk), .rst_n(rst_n), .Clear(Clear),
        .RegWrite1(RegWrite1), .W1(W1), .WD1(WD1),
        .RegWrite2(RegWrite2), .W2(W2), .WD2(WD2),
        .R1(R1), .R2(R2), .R3(R3),
        .RD1(s_RD1), .RD2(s_RD2), .RD3(s_RD3), .Busy(s_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Clear = 1'b0; RegWrite1 = 1'b0; RegWrite2 = 1'b0;
        W1 = '0; W2 = '0; WD1 = '0; WD2 = '0;
    endtask

    initial begin
        logic [31:0] exp_v;
        int          busy_cnt;

        rst_n = 1'b0;
        idle_inputs();
        R1 = 5'd7; R2 = 5'd31; R3 = 5'd0;

        // 1. Reset sweep
        step();
        rst_n = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (Busy === 1'b1) busy_cnt++;
            check("sweep_rd1_zero", RD1, 32'h0);
            step();
        end
        check("sweep_busy_cycles", busy_cnt, 32'd32);
        @(negedge clk);
        check("busy_after_sweep", {31'b0, Busy}, 32'h0);
        check("rd1_r7", RD1, 32'h0000_0007);
        check("rd2_r31", RD2, 32'h0000_001F);
        check("rd3_r0", RD3, 32'h0);
        check("d24_rd1_r7", s_RD1, 32'h0000_0007);
        check("d24_rd2_r31_oor", s_RD2, 32'h0);

        // 2. Dual-write collision on address 5
        step();
        RegWrite1 = 1'b1; W1 = 5'd5; WD1 = 32'hAAAA_0000;
        RegWrite2 = 1'b1; W2 = 5'd5; WD2 = 32'h5555_FFFF;
        R1 = 5'd5;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        exp_v = 32'h5555_FFFF;
`else
        exp_v = 32'h0000_0005;
`endif
        check("collide_pre_edge", RD1, exp_v);
        step();
        idle_inputs();
        @(negedge clk);
        check("collide_port2_wins", RD1, 32'h5555_FFFF);

        // 3. Register 0 and out-of-range
        step();
        RegWrite1 = 1'b1; W1 = 5'd0; WD1 = 32'hDEAD_BEEF; R1 = 5'd0;
        @(negedge clk);
        check("r0_pre_edge", RD1, 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
        check("r0_after_write", RD1, 32'h0);
        RegWrite2 = 1'b1; W2 = 5'd30; WD2 = 32'h1357_9BDF;
        step();
        idle_inputs();
        R1 = 5'd23; R3 = 5'd30;
        @(negedge clk);
        check("d24_rd3_r30", s_RD3, 32'h0);
        check("d24_rd1_r23", s_RD1, 32'h0000_0017);
        check("d32_rd3_r30", RD3, 32'h1357_9BDF);

        // 4. Bypass behaviour on all read ports
        step();
        RegWrite1 = 1'b1; W1 = 5'd9; WD1 = 32'h1234_5678; R2 = 5'd9; R3 = 5'd9;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        exp_v = 32'h1234_5678;
`else
        exp_v = 32'h0000_0009;
`endif
        check("bypass_rd2", RD2, exp_v);
        check("bypass_rd3", RD3, exp_v);
        step();
        idle_inputs();
        @(negedge clk);
        check("w9_after_edge", RD2, 32'h1234_5678);
        RegWrite1 = 1'b1; W1 = 5'd10; WD1 = 32'h0000_1111;
        RegWrite2 = 1'b1; W2 = 5'd10; WD2 = 32'h0000_2222;
        R1 = 5'd10;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_v = 32'h0000_2222;
`else
        exp_v = 32'h0000_000A;
`endif
        check("bypass_prio", RD1, exp_v);
        step();
        idle_inputs();

        // 5. Clear with writes attempted during sweep
        RegWrite1 = 1'b1; W1 = 5'd3; WD1 = 32'hFFFF_FFFF;
        step();
        idle_inputs();
        R1 = 5'd3; R2 = 5'd4;
        @(negedge clk);
        check("w3_written", RD1, 32'hFFFF_FFFF);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        RegWrite2 = 1'b1; W2 = 5'd4; WD2 = 32'hCAFE_F00D;
        busy_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (Busy === 1'b1) busy_cnt++;
            if (i == 16) check("clear_sweep_rd1_zero", RD1, 32'h0);
            step();
        end
        idle_inputs();
        check("clear_busy_cycles", busy_cnt, 32'd32);
        @(negedge clk);
        check("clear_busy_low", {31'b0, Busy}, 32'h0);
        check("clear_rd1_r3", RD1, 32'h0000_0003);
        check("clear_rd2_r4", RD2, 32'h0000_0004);

        // 6. Reset mid-sweep restarts from entry 0
        step();
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Busy === 1'b1) busy_cnt++;
            step();
        end
        check("rst_mid_busy_cycles", busy_cnt, 32'd32);
        for (int i = 0; i < 32; i++) begin
            R1 = 5'(i); R2 = 5'(i); R3 = 5'(31 - i);
            #1;
            check("final_rd1", RD1, 32'(i));
            check("final_rd3", RD3, 32'(31 - i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read register file.
- 3 asynchronous read ports and 2 synchronous write ports with fixed priority.
- Clearing is done by a reset/clear sweep state machine that walks the array one entry per cycle, rather than by an initial block.
- Sits in the decode stage of the 3-bus datapath. Read port 3 serves the third operand bus and store data.

Parameters:
- Width, 32, data bits per register.
- Depth, 32, number of registers (2..256; need not be a power of two).
- AddrW, 5, address bits; must satisfy 2**AddrW >= Depth.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Clear  in  1  request a full clear sweep; sampled only in IDLE.
- RegWrite1  in  1  write enable, port 1.
- W1  in  AddrW  write address, port 1.
- WD1  in  Width  write data, port 1.
- RegWrite2  in  1  write enable, port 2 (higher priority).
- W2  in  AddrW  write address, port 2.
- WD2  in  Width  write data, port 2.
- R1, R2, R3  in  AddrW  read addresses.
- RD1, RD2, RD3  out  Width  read data (combinational).
- Busy  out  1  high while a sweep is in progress.

Behaviour:
- Reset:
  - rst_n low at a rising edge forces state SWEEP, sweep counter = 0, Busy = 1 on the next cycle.
  - This applies from any state, including mid-sweep, which restarts at entry 0.
  - Array contents are not touched on the reset edge itself.
- States:
  - SWEEP: each cycle writes entry[cnt] <= cnt, zero-extended to Width (identity pattern for debug), then cnt++.
  - SWEEP -> IDLE on the edge that writes entry Depth-1. The sweep therefore lasts exactly Depth cycles.
  - Busy drops in the first IDLE cycle.
  - IDLE: Clear = 1 at an edge -> SWEEP with cnt = 0.
  - IDLE: Clear = 0 -> stay in IDLE.
  - Clear is ignored during SWEEP.
- During SWEEP:
  - RegWrite1 and RegWrite2 are ignored; no entry is written except by the sweep.
  - RD1, RD2 and RD3 read 0.
- Writes in IDLE:
  - Port n with RegWriten = 1 writes WDn to entry[Wn] at the rising edge.
  - Writes to address 0 are discarded; entry 0 always reads 0.
  - Writes to an address >= Depth are discarded.
  - If both ports target the same address in the same cycle, port 2's data is stored.
- Reads:
  - RDk = 0 if Rk == 0, Rk >= Depth, or Busy = 1.
  - Otherwise RDk = entry[Rk], subject to bypass (see Optional Feature).
  - Reads are combinational from address to data, with zero cycles of latency.
- Write latency: a value written at edge t is visible on all read ports from edge t onward. With bypass enabled, it is visible in cycle t itself.
- Entry 0 is swept to 0 like any other entry. Its read masking keeps it 0 regardless.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data when the read address equals an enabled write address.
  - The write address must be nonzero, < Depth, and Busy must be 0.
  - Port 2 data takes precedence over port 1 if both match.
  - This gives write-before-read semantics for a single-cycle pipeline.
- Undefined:
  - No forwarding; reads return the stored value (read-before-write).
  - The forwarding muxes are absent from the netlist.

Test Plan:
1. Reset sweep: hold rst_n = 0 for 1 cycle, release -> Busy = 1 for exactly 32 cycles and RD1 = 0 throughout. After Busy falls, R1 = 7 -> RD1 = 0x00000007 and R2 = 31 -> RD2 = 0x0000001F.
2. Dual-write collision: in IDLE, RegWrite1 = RegWrite2 = 1, W1 = W2 = 5, WD1 = 0xAAAA0000, WD2 = 0x5555FFFF -> next cycle RD1 (R1 = 5) = 0x5555FFFF.
3. Register 0 and out-of-range: write 0xDEADBEEF to address 0 -> RD1 (R1 = 0) = 0. With Depth = 24, write to address 30 -> no entry changes and R3 = 30 reads 0.
4. Bypass (REGFILE_BYPASS_EN defined): RegWrite1 = 1, W1 = 9, WD1 = 0x12345678, R2 = 9 in the same cycle -> RD2 = 0x12345678 before the edge. Without the macro, RD2 = 0x00000009 until the edge.
5. Clear and writes during sweep: in IDLE, write 0xFFFFFFFF to address 3, then pulse Clear. During the sweep, assert RegWrite2 to address 4 with 0xCAFEF00D -> after the sweep, RD1 (R1 = 3) = 3 and RD2 (R2 = 4) = 4.
6. Reset mid-sweep: assert rst_n = 0 at sweep cycle 10 -> cnt restarts at 0 and Busy stays high for 32 further cycles after release. All entries read their index afterward.
